wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone classic single-access initiator. It drives the wbs_* slave port of the I2C core wrapper from a simple command/response stream.
- The testbench sequencer or an on-chip controller issues a read/write command. The block runs one Wishbone cycle, waits for ack or timeout, and returns a response.
- Only one transaction is outstanding at any time.

Parameters:
- ADR_W, 3, Wishbone address width.
- DAT_W, 8, Wishbone data width.
- TIMEOUT, 16, maximum cycles STB may stay asserted without ACK. Legal range is 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  ADR_W  target register address
- cmd_dat  in  DAT_W  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_dat  out  DAT_W  read data (0 for writes and on error)
- rsp_err  out  1  1 = timeout, no ack received
- wbm_adr_o  out  ADR_W  to wbs_adr_i
- wbm_dat_o  out  DAT_W  to wbs_dat_i
- wbm_dat_i  in  DAT_W  from wbs_dat_o
- wbm_we_o  out  1  to wbs_we_i
- wbm_stb_o  out  1  to wbs_stb_i
- wbm_cyc_o  out  1  to wbs_cyc_i
- wbm_ack_i  in  1  from wbs_ack_o

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - cmd_ready=0, rsp_valid=0, rsp_err=0, wbm_stb_o=0, wbm_cyc_o=0, wbm_we_o=0.
  - rsp_dat, wbm_adr_o and wbm_dat_o go to 0.
  - The timeout counter goes to 0.
  - Reset mid-transaction drops CYC/STB immediately and discards the transaction; no response is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1, asserted as a registered decode of state==IDLE.
  - On handshake, register cmd_adr/cmd_dat/cmd_we onto the wbm_* outputs and go to BUS.
  - wbm_cyc_o and wbm_stb_o are 1 in the next cycle (1-cycle latency from accept to STB).
- BUS:
  - cyc=stb=1; adr/dat/we held stable; cmd_ready=0.
  - The counter increments each BUS cycle, starting at 0.
  - ACK is sampled on each rising edge. If wbm_ack_i=1:
    - Capture rsp_dat = wbm_dat_i for reads, or 0 for writes.
    - Set rsp_err=0, drop cyc/stb on the next cycle, and go to RESP.
  - A zero-wait slave (ACK in the first STB cycle) completes in exactly 1 BUS cycle.
  - If the counter reaches TIMEOUT-1 with ack=0:
    - Drop cyc/stb, set rsp_dat=0, rsp_err=1, and go to RESP.
  - ACK and timeout in the same cycle: ACK wins and rsp_err=0.
- RESP:
  - rsp_valid=1; rsp_dat/rsp_err held stable.
  - On rsp_valid && rsp_ready, go to IDLE and clear rsp_valid.
  - The counter clears on entry to IDLE.
  - With rsp_ready held 1, the minimum turnaround is accept → STB (1) → RESP (1) → IDLE: one command per 3 cycles.
- wbm_ack_i is ignored whenever state != BUS; a stray ACK has no effect.
- cmd_valid asserted while not IDLE: the command is not accepted and the source must hold it (cmd_ready=0).
- wbm_stb_o == wbm_cyc_o at all times. The block never asserts STB outside CYC.
- All outputs are registered. There is no combinational path from wbm_ack_i or rsp_ready to any output.
- Counter width is $clog2(TIMEOUT+1), unsigned, and saturates (it never wraps).

Decomposition:
- Package wb_cmd_master_pkg holds:
  - the typedef enum logic [1:0] state_t {IDLE, BUS, RESP};
  - the command struct {we, adr, dat};
  - the response struct {dat, err};
  - localparam defaults for ADR_W/DAT_W/TIMEOUT.
- One sub-module, wb_timeout_cnt:
  - Inputs: clear, enable.
  - Outputs: an expired flag and the count.
  - Parameter: TIMEOUT.
  - Async active-low reset on the same rst.
- Everything else lives in a single always_ff FSM plus registered outputs.

Test Plan:
- Write 0xA5 to addr 3, slave acks after 2 wait cycles:
  - STB high for 3 cycles with adr=3, dat_o=0xA5, we=1.
  - Response: rsp_valid=1, rsp_err=0, rsp_dat=0x00.
- Read addr 5, zero-wait slave returns 0x3C in the first STB cycle:
  - STB high exactly 1 cycle.
  - Response: rsp_dat=0x3C, rsp_err=0, rsp_valid 2 cycles after cmd accept.
- Read with a slave that never acks, TIMEOUT=16:
  - STB high exactly 16 cycles, then drops.
  - Response: rsp_err=1, rsp_dat=0x00.
- ACK on the final timeout cycle (cycle 16) for a read returning 0x7E:
  - Response: rsp_err=0, rsp_dat=0x7E.
- Backpressure: rsp_ready=0 for 5 cycles, then a second cmd_valid presented:
  - rsp_valid and rsp_dat held stable throughout; cmd_ready stays 0.
  - The second command is accepted only after the rsp handshake.
  - A stray ACK during RESP has no effect.
- rst pulled low in the 2nd STB cycle:
  - cyc/stb go 0 asynchronously and all outputs return to reset values.
  - No rsp_valid after release.
  - The next command runs normally.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// rtl/wb_cmd_master_pkg.sv - shared types and defaults for the Wishbone command master
package wb_cmd_master_pkg;

  localparam int DEF_ADR_W   = 3;
  localparam int DEF_DAT_W   = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [DEF_ADR_W-1:0] adr;
    logic [DEF_DAT_W-1:0] dat;
  } cmd_t;

  typedef struct packed {
    logic [DEF_DAT_W-1:0] dat;
    logic                 err;
  } rsp_t;

  // Counter must hold TIMEOUT itself so it can saturate one past the last bus cycle.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// rtl/wb_timeout_cnt.sv - saturating bus-cycle counter with an expiry flag
module wb_timeout_cnt
  import wb_cmd_master_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int CNT_W  = cnt_width(TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic             expired_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != SAT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q >= LAST);
  assign count_o   = count_q;

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone classic single-access initiator driven by a command/response stream
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int ADR_W   = DEF_ADR_W,
  parameter int DAT_W   = DEF_DAT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [ADR_W-1:0] cmd_adr,
  input  logic [DAT_W-1:0] cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DAT_W-1:0] rsp_dat,
  output logic             rsp_err,
  output logic [ADR_W-1:0] wbm_adr_o,
  output logic [DAT_W-1:0] wbm_dat_o,
  input  logic [DAT_W-1:0] wbm_dat_i,
  output logic             wbm_we_o,
  output logic             wbm_stb_o,
  output logic             wbm_cyc_o,
  input  logic             wbm_ack_i
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUS  = BUS;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]       state_q, state_d;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic [DAT_W-1:0] rsp_dat_q;
  logic             rsp_err_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dat_q;
  logic             we_q;
  logic             cyc_q;

  logic             cmd_fire, rsp_fire, bus_ack, bus_timeout;
  logic             tmo_expired, tmo_last;
  logic [CNT_W-1:0] tmo_count;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (rsp_fire),
    .enable_i  (state_q == ST_BUS),
    .expired_o (tmo_expired),
    .count_o   (tmo_count)
  );

  // Fire the timeout only on the limit cycle itself, never from a saturated count.
  assign tmo_last    = tmo_expired && (tmo_count <= CNT_W'(TIMEOUT - 1));

  assign cmd_fire    = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign rsp_fire    = (state_q == ST_RESP) && rsp_ready;
  assign bus_ack     = (state_q == ST_BUS) && wbm_ack_i;
  assign bus_timeout = (state_q == ST_BUS) && !wbm_ack_i && tmo_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire)               state_d = ST_BUS;
      ST_BUS:  if (bus_ack || bus_timeout) state_d = ST_RESP;
      ST_RESP: if (rsp_fire)               state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // cmd_ready follows the next state so it drops on the very edge that accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            adr_q <= cmd_adr;
            dat_q <= cmd_dat;
            we_q  <= cmd_we;
            cyc_q <= 1'b1;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= we_q ? '0 : wbm_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
          end else if (bus_timeout) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb/tb_wb_cmd_master.sv - self-checking bench for wb_cmd_master against a transaction-level model
`timescale 1ns/1ps
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int TIMEOUT = DEF_TIMEOUT;
  localparam int NEVER   = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [2:0] cmd_adr;
  logic [7:0] cmd_dat;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_dat;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o, wbm_dat_i;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    int         stb;
    logic       err;
    logic [7:0] dat;
  } exp_t;

  wb_cmd_master #(.ADR_W(3), .DAT_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // Slave acks after wait_n wait states; anything at or beyond TIMEOUT waits is a timeout.
  function automatic exp_t model(input cmd_t c, input int wait_n, input logic [7:0] rdata);
    exp_t e;
    if (wait_n < TIMEOUT) begin
      e.stb = wait_n + 1;
      e.err = 1'b0;
      e.dat = c.we ? 8'h00 : rdata;
    end else begin
      e.stb = TIMEOUT;
      e.err = 1'b1;
      e.dat = 8'h00;
    end
    return e;
  endfunction

  task automatic do_cmd(input cmd_t c, input int wait_n, input logic [7:0] rdata,
                        output int stb_n, output int lat, output bit bus_bad, output bit hung);
    int guard;
    stb_n = 0; lat = 0; bus_bad = 1'b0; hung = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = c.we; cmd_adr = c.adr; cmd_dat = c.dat;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      hung = 1'b1;
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    guard = 0;
    while (rsp_valid !== 1'b1 && guard < 60) begin
      if (wbm_stb_o !== wbm_cyc_o) bus_bad = 1'b1;
      if (wbm_stb_o === 1'b1) begin
        stb_n++;
        if (wbm_adr_o !== c.adr || wbm_we_o !== c.we || wbm_dat_o !== c.dat) bus_bad = 1'b1;
        wbm_ack_i = (stb_n == wait_n + 1);
        wbm_dat_i = wbm_ack_i ? rdata : 8'($urandom);
      end else begin
        wbm_ack_i = 1'b0;
      end
      @(negedge clk);
      lat++;
      guard++;
    end
    wbm_ack_i = 1'b0;
    if (guard >= 60) hung = 1'b1;
  endtask

  task automatic release_rsp(input int delay);
    repeat (delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, wbm_stb_o, wbm_cyc_o, wbm_we_o} !== 6'b0 ||
        rsp_dat !== 8'h00 || wbm_adr_o !== 3'd0 || wbm_dat_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b vld=%b err=%b stb=%b cyc=%b we=%b dat=%h adr=%h do=%h, want all 0",
               cmd_ready, rsp_valid, rsp_err, wbm_stb_o, wbm_cyc_o, wbm_we_o, rsp_dat, wbm_adr_o, wbm_dat_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b rsp_valid=%b, want 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_write_wait2();
    cmd_t c; exp_t e; int s, l; bit bad, hung;
    c.we = 1'b1; c.adr = 3'd3; c.dat = 8'hA5;
    e = model(c, 2, 8'h00);
    do_cmd(c, 2, 8'h00, s, l, bad, hung);
    checks++;
    if (hung || s != e.stb) begin
      errors++;
      $display("FAIL write_stb_cycles: got %0d want %0d hung=%0b", s, e.stb, hung);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL write_bus_signals: adr/dat/we/cyc wrong got 1 want 0"); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_dat !== e.dat) begin
      errors++;
      $display("FAIL write_rsp: vld=%b err=%b dat=%h want 1 %b %h", rsp_valid, rsp_err, rsp_dat, e.err, e.dat);
    end
    release_rsp(0);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_release: vld=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_zero_wait();
    cmd_t c; exp_t e; int s, l; bit bad, hung;
    c.we = 1'b0; c.adr = 3'd5; c.dat = 8'h11;
    e = model(c, 0, 8'h3C);
    do_cmd(c, 0, 8'h3C, s, l, bad, hung);
    checks++;
    if (hung || s != 1 || l != 2 || bad) begin
      errors++;
      $display("FAIL zero_wait_timing: stb=%0d lat=%0d bad=%0b want 1 2 0", s, l, bad);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_dat !== e.dat) begin
      errors++;
      $display("FAIL zero_wait_rsp: vld=%b err=%b dat=%h want 1 %b %h", rsp_valid, rsp_err, rsp_dat, e.err, e.dat);
    end
    release_rsp(1);
  endtask

  task automatic test_timeout();
    cmd_t c; exp_t e; int s, l; bit bad, hung;
    c.we = 1'b0; c.adr = 3'd1; c.dat = 8'h00;
    e = model(c, NEVER, 8'h99);
    do_cmd(c, NEVER, 8'h99, s, l, bad, hung);
    checks++;
    if (hung || s != TIMEOUT || bad) begin
      errors++;
      $display("FAIL timeout_stb_cycles: got %0d want %0d bad=%0b", s, TIMEOUT, bad);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_dat !== e.dat) begin
      errors++;
      $display("FAIL timeout_rsp: vld=%b err=%b dat=%h want 1 %b %h", rsp_valid, rsp_err, rsp_dat, e.err, e.dat);
    end
    release_rsp(0);
  endtask

  task automatic test_ack_last();
    cmd_t c; exp_t e; int s, l; bit bad, hung;
    c.we = 1'b0; c.adr = 3'd7; c.dat = 8'h00;
    e = model(c, TIMEOUT - 1, 8'h7E);
    do_cmd(c, TIMEOUT - 1, 8'h7E, s, l, bad, hung);
    checks++;
    if (hung || s != TIMEOUT || bad || rsp_err !== 1'b0 || rsp_dat !== 8'h7E || e.dat !== 8'h7E) begin
      errors++;
      $display("FAIL ack_on_last_cycle: stb=%0d err=%b dat=%h want %0d 0 7e", s, rsp_err, rsp_dat, TIMEOUT);
    end
    release_rsp(0);
  endtask

  task automatic test_back_to_back();
    int n_stb;
    n_stb = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 3'd2; cmd_dat = 8'h00;
    rsp_ready = 1'b1; wbm_dat_i = 8'h42;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wbm_ack_i = wbm_stb_o;
      if (wbm_stb_o === 1'b1) n_stb++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; wbm_ack_i = 1'b0;
    checks++;
    if (n_stb != 12 / 3) begin
      errors++;
      $display("FAIL back_to_back_rate: got %0d transactions want %0d", n_stb, 12 / 3);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    cmd_t c; int s, l; bit bad, hung;
    c.we = 1'b0; c.adr = 3'd2; c.dat = 8'h00;
    do_cmd(c, 1, 8'h5A, s, l, bad, hung);
    checks++;
    if (hung || s != 2 || rsp_dat !== 8'h5A) begin
      errors++;
      $display("FAIL bp_first_read: stb=%0d dat=%h want 2 5a", s, rsp_dat);
    end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 3'd4; cmd_dat = 8'hC3;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wbm_ack_i = (i == 1 || i == 3);
      wbm_dat_i = 8'hFF;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== 8'h5A || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || wbm_stb_o !== 1'b0) bad = 1'b1;
    end
    wbm_ack_i = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL bp_hold: response not held stable got 1 want 0"); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || wbm_stb_o !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake: vld=%b stb=%b rdy=%b want 0 0 1", rsp_valid, wbm_stb_o, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (wbm_stb_o !== 1'b1 || wbm_adr_o !== 3'd4 || wbm_dat_o !== 8'hC3 || wbm_we_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept: stb=%b adr=%h dat=%h we=%b want 1 4 c3 1", wbm_stb_o, wbm_adr_o, wbm_dat_o, wbm_we_o);
    end
    wbm_ack_i = 1'b1;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 8'h00) begin
      errors++;
      $display("FAIL bp_second_rsp: vld=%b err=%b dat=%h want 1 0 00", rsp_valid, rsp_err, rsp_dat);
    end
    release_rsp(0);
  endtask

  task automatic test_reset_mid();
    cmd_t c; int s, l, guard; bit bad, hung;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 3'd6; cmd_dat = 8'h00;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({wbm_stb_o, wbm_cyc_o, wbm_we_o, cmd_ready, rsp_valid, rsp_err} !== 6'b0 ||
        wbm_adr_o !== 3'd0 || wbm_dat_o !== 8'h00 || rsp_dat !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs: stb=%b cyc=%b adr=%h rdy=%b vld=%b want all 0",
               wbm_stb_o, wbm_cyc_o, wbm_adr_o, cmd_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wbm_stb_o !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL mid_reset_no_rsp: response or cycle after reset got 1 want 0"); end
    c.we = 1'b1; c.adr = 3'd6; c.dat = 8'h3D;
    do_cmd(c, 3, 8'h00, s, l, bad, hung);
    checks++;
    if (hung || bad || s != 4 || rsp_err !== 1'b0 || rsp_dat !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_next_cmd: stb=%0d bad=%0b err=%b dat=%h want 4 0 0 00", s, bad, rsp_err, rsp_dat);
    end
    release_rsp(0);
  endtask

  task automatic test_random();
    cmd_t c; exp_t e; int s, l, w; bit bad, hung; logic [7:0] rd;
    for (int n = 0; n < 25; n++) begin
      c.we = 1'($urandom); c.adr = 3'($urandom); c.dat = 8'($urandom);
      w = $urandom_range(0, TIMEOUT + 4);
      rd = 8'($urandom);
      e = model(c, w, rd);
      do_cmd(c, w, rd, s, l, bad, hung);
      checks++;
      if (hung || bad || s != e.stb || l != e.stb + 1 || rsp_valid !== 1'b1 ||
          rsp_err !== e.err || rsp_dat !== e.dat) begin
        errors++;
        $display("FAIL random_txn %0d: stb=%0d lat=%0d err=%b dat=%h want stb=%0d lat=%0d err=%b dat=%h",
                 n, s, l, rsp_err, rsp_dat, e.stb, e.stb + 1, e.err, e.dat);
      end
      release_rsp($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;
    test_reset();
    test_write_wait2();
    test_read_zero_wait();
    test_timeout();
    test_ack_last();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
